// File: rtl/vga_sync_pipe_pkg.sv
// vga_sync_pipe_pkg: shared VGA mode timing, sync FSM states and the pipe word layout
package vga_sync_pipe_pkg;
   localparam int VGA_H_VISIBLE     = 640;
   localparam int VGA_H_FRONT_PORCH = 16;
   localparam int VGA_H_SYNC_PULSE  = 96;
   localparam int VGA_H_WHOLE_LINE  = 800;
   localparam int VGA_V_VISIBLE     = 480;
   localparam int VGA_V_FRONT_PORCH = 10;
   localparam int VGA_V_SYNC_PULSE  = 2;
   localparam int VGA_V_WHOLE_FRAME = 525;

   typedef enum logic {SYNC_WAIT = 1'b0, RUN = 1'b1} state_t;

   // decoded pixel attributes, all active-high so an all-zero word is "inactive"
   typedef struct packed {
      logic hs;
      logic vs;
      logic vis;
      logic org;
   } pix_t;
endpackage

// File: rtl/vga_sync_pipe_if.sv
// vga_sync_pipe_if: pixel iterator coordinates in, registered VGA timing strobes out
interface vga_sync_pipe_if;
   logic       inc;
   logic [9:0] x;
   logic [9:0] y;
   logic       hsync;
   logic       vsync;
   logic       visible;
   logic       frame_start;
   logic       locked;
   logic       resync_err;

   modport master (output inc, x, y, input hsync, vsync, visible, frame_start, locked, resync_err);
   modport slave  (input inc, x, y, output hsync, vsync, visible, frame_start, locked, resync_err);
endinterface

// File: rtl/vga_sync_pipe_delay_line.sv
// vga_delay_line: enable-gated shift register; a clear keeps only the word being shifted in
module vga_delay_line #(
   parameter int W     = 4,
   parameter int DEPTH = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en_i,
   input  logic         clr_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);
   localparam int DW = W * DEPTH;
   logic [DW-1:0] sr_q, sr_d, shifted;

   if (DEPTH == 1) begin : g_one
      assign shifted = d_i;
   end else begin : g_many
      assign shifted = {sr_q[DW-W-1:0], d_i};
   end

   // next contents: normal shift, or flush older words leaving only the new one
   always_comb sr_d = clr_i ? DW'(d_i) : shifted;

   // advance only on enabled cycles
   always_ff @(posedge clk or negedge reset)
      if (!reset) sr_q <= '0;
      else if (en_i) sr_q <= sr_d;

   assign q_o = sr_q[DW-1 -: W];
endmodule

// File: rtl/vga_sync_pipe.sv
// vga_sync_pipe: decodes VGA sync/visible from iterator coordinates and delays them in lockstep with inc
module vga_sync_pipe import vga_sync_pipe_pkg::*; #(
   parameter int H_VISIBLE     = VGA_H_VISIBLE,
   parameter int H_FRONT_PORCH = VGA_H_FRONT_PORCH,
   parameter int H_SYNC_PULSE  = VGA_H_SYNC_PULSE,
   parameter int H_WHOLE_LINE  = VGA_H_WHOLE_LINE,
   parameter int V_VISIBLE     = VGA_V_VISIBLE,
   parameter int V_FRONT_PORCH = VGA_V_FRONT_PORCH,
   parameter int V_SYNC_PULSE  = VGA_V_SYNC_PULSE,
   parameter int V_WHOLE_FRAME = VGA_V_WHOLE_FRAME,
   parameter int PIPE_DELAY    = 2
) (
   input logic            clk,
   input logic            reset,
   vga_sync_pipe_if.slave bus
);
   localparam logic [9:0] HS_BEG = 10'(H_VISIBLE + H_FRONT_PORCH);
   localparam logic [9:0] HS_END = 10'(H_VISIBLE + H_FRONT_PORCH + H_SYNC_PULSE);
   localparam logic [9:0] VS_BEG = 10'(V_VISIBLE + V_FRONT_PORCH);
   localparam logic [9:0] VS_END = 10'(V_VISIBLE + V_FRONT_PORCH + V_SYNC_PULSE);
   localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
   localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
   localparam logic [9:0] H_LAST = 10'(H_WHOLE_LINE - 1);
   localparam logic [9:0] V_LAST = 10'(V_WHOLE_FRAME - 1);

   state_t     state_q, state_d;
   pix_t       raw, gated, tail, tail_v;
   logic [9:0] exp_x_q, exp_y_q, nx, ny;
   logic       mis, run_d;
   logic       hsync_q, vsync_q, visible_q, frame_start_q, locked_q, resync_err_q;

   // decode the incoming pixel and the coordinate the iterator must present next
   always_comb begin
      raw.hs  = bus.x >= HS_BEG && bus.x < HS_END;
      raw.vs  = bus.y >= VS_BEG && bus.y < VS_END;
      raw.vis = bus.x < H_VIS && bus.y < V_VIS;
      raw.org = bus.x == '0 && bus.y == '0;
      nx      = bus.x == H_LAST ? '0 : bus.x + 10'd1;
      ny      = bus.x != H_LAST ? bus.y : bus.y == V_LAST ? '0 : bus.y + 10'd1;
   end

   // lock on the origin; a coordinate jump drops lock unless it lands on the origin
   always_comb begin
      mis     = state_q == RUN && bus.inc && (bus.x != exp_x_q || bus.y != exp_y_q);
      run_d   = (bus.inc && raw.org) || (state_q == RUN && !mis);
      state_d = run_d ? RUN : SYNC_WAIT;
      gated   = ((state_q == RUN && !mis) || raw.org) ? raw : '0;
      tail_v  = (mis && PIPE_DELAY > 1) ? '0 : tail;
   end

   if (PIPE_DELAY > 1) begin : g_chain
      vga_delay_line #(.W($bits(pix_t)), .DEPTH(PIPE_DELAY - 1)) u_dl (
         .clk   (clk),
         .reset (reset),
         .en_i  (bus.inc),
         .clr_i (mis),
         .d_i   (gated),
         .q_o   (tail)
      );
   end else begin : g_direct
      assign tail = gated;
   end

   // FSM state, expected coordinate and the output stage that closes the delay chain
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= SYNC_WAIT;
         exp_x_q       <= '0;
         exp_y_q       <= '0;
         hsync_q       <= 1'b1;
         vsync_q       <= 1'b1;
         visible_q     <= 1'b0;
         frame_start_q <= 1'b0;
         locked_q      <= 1'b0;
         resync_err_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         locked_q      <= run_d;
         resync_err_q  <= mis;
         frame_start_q <= run_d && bus.inc && tail_v.org;
         if (bus.inc) begin
            exp_x_q <= nx;
            exp_y_q <= ny;
         end
         if (!run_d) begin
            hsync_q   <= 1'b1;
            vsync_q   <= 1'b1;
            visible_q <= 1'b0;
         end else if (bus.inc) begin
            hsync_q   <= !tail_v.hs;
            vsync_q   <= !tail_v.vs;
            visible_q <= tail_v.vis;
         end
      end
   end

   assign bus.hsync       = hsync_q;
   assign bus.vsync       = vsync_q;
   assign bus.visible     = visible_q;
   assign bus.frame_start = frame_start_q;
   assign bus.locked      = locked_q;
   assign bus.resync_err  = resync_err_q;
endmodule

// File: tb/tb_vga_sync_pipe.sv
// tb_vga_sync_pipe: randomized iterator stream scored against a pixel-queue model of the sync pipe
module tb_vga_sync_pipe;
   localparam int HV = 16, HFP = 3, HSP = 5, HW = 28;
   localparam int VV = 6, VFP = 2, VSP = 2, VW = 12;
   localparam int PD = 2;
   localparam int FRAME = HW * VW;

   typedef struct packed {
      logic hs;
      logic vs;
      logic vis;
      logic fs;
      logic lk;
      logic err;
   } obs_t;

   localparam obs_t IDLE = 6'b110000;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   checks = 0;
   int   failures = 0;

   obs_t sb[$];
   bit   m_lk;
   int   m_ex, m_ey;
   int   px_q[$], py_q[$];
   obs_t m_out;
   int   cx, cy;

   vga_sync_pipe_if bus();

   vga_sync_pipe #(
      .H_VISIBLE(HV), .H_FRONT_PORCH(HFP), .H_SYNC_PULSE(HSP), .H_WHOLE_LINE(HW),
      .V_VISIBLE(VV), .V_FRONT_PORCH(VFP), .V_SYNC_PULSE(VSP), .V_WHOLE_FRAME(VW),
      .PIPE_DELAY(PD)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic obs_t observe();
      return {bus.hsync, bus.vsync, bus.visible, bus.frame_start, bus.locked, bus.resync_err};
   endfunction

   task automatic check(input string nm, input obs_t act, input obs_t exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s t=%0t {hs,vs,vis,fs,lk,err} actual=%b required=%b", nm, $time, act, exp);
      end
   endtask

   function automatic void model_reset();
      m_lk = 1'b0;
      m_ex = 0;
      m_ey = 0;
      px_q.delete();
      py_q.delete();
      m_out = IDLE;
   endfunction

   // each accepted pixel reappears PD inc-cycles later; anything unlocked shows idle levels
   task automatic model_step(input bit inc, input int x, input int y);
      obs_t o;
      int ox, oy;
      o = m_out;
      o.fs = 1'b0;
      o.err = 1'b0;
      if (inc) begin
         o.hs = 1'b1;
         o.vs = 1'b1;
         o.vis = 1'b0;
         if (m_lk && (x != m_ex || y != m_ey)) begin
            o.err = 1'b1;
            m_lk = 1'b0;
            px_q.delete();
            py_q.delete();
         end
         if (!m_lk && x == 0 && y == 0) m_lk = 1'b1;
         if (m_lk) begin
            px_q.push_back(x);
            py_q.push_back(y);
            if (px_q.size() == PD) begin
               ox = px_q.pop_front();
               oy = py_q.pop_front();
               o.hs  = !(ox >= HV + HFP && ox < HV + HFP + HSP);
               o.vs  = !(oy >= VV + VFP && oy < VV + VFP + VSP);
               o.vis = ox < HV && oy < VV;
               o.fs  = ox == 0 && oy == 0;
            end
         end
         m_ex = (x + 1) % HW;
         m_ey = (x == HW - 1) ? (y + 1) % VW : y;
      end
      o.lk = m_lk;
      m_out = o;
      sb.push_back(o);
   endtask

   task automatic step(input bit inc, input int x, input int y);
      @(negedge clk);
      bus.inc = inc;
      bus.x = 10'(x);
      bus.y = 10'(y);
      model_step(inc, x, y);
   endtask

   task automatic advance();
      cx = cx + 1;
      if (cx == HW) begin
         cx = 0;
         cy = (cy + 1) % VW;
      end
   endtask

   task automatic run(input int n, input int p_inc);
      for (int i = 0; i < n; i++) begin
         if ($urandom_range(99) < p_inc) begin
            step(1'b1, cx, cy);
            advance();
         end else begin
            step(1'b0, int'($urandom_range(1023)), int'($urandom_range(1023)));
         end
      end
   endtask

   task automatic jump(input int jx, input int jy);
      step(1'b1, jx, jy);
      cx = jx;
      cy = jy;
      advance();
   endtask

   task automatic run_to(input int tx);
      for (int i = 0; i < HW && cx != tx; i++) run(1, 100);
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) check("scoreboard", observe(), sb.pop_front());
      end
   end

   initial begin
      model_reset();
      bus.inc = 1'b1;
      bus.x = '0;
      bus.y = '0;
      repeat (3) begin
         @(negedge clk);
         check("reset_state", observe(), IDLE);
      end
      @(negedge clk);
      reset = 1'b1;
      bus.inc = 1'b1;
      bus.x = 10'd5;
      bus.y = 10'd0;
      model_step(1'b1, 5, 0);
      cx = 5;
      cy = 0;
      advance();
      run(FRAME + 40, 100);
      run(2 * FRAME, 70);
      run_to(8);
      run(10, 0);
      run(40, 100);
      run_to(10);
      jump(20, cy);
      run(FRAME + 20, 100);
      run_to(7);
      jump(0, 0);
      run(FRAME, 80);
      repeat (5) begin
         run(int'($urandom_range(30, 120)), 90);
         jump(int'($urandom_range(HW - 1)), int'($urandom_range(VW - 1)));
      end
      run(FRAME + 20, 100);
      run(FRAME / 2, 100);
      @(posedge clk);
      #3;
      reset = 1'b0;
      #1;
      check("async_reset", observe(), IDLE);
      model_reset();
      repeat (2) begin
         @(negedge clk);
         check("reset_hold", observe(), IDLE);
      end
      @(posedge clk);
      #2;
      reset = 1'b1;
      run(FRAME + 30, 85);
      repeat (3) @(posedge clk);
      #2;
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain pending=%0d required=0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/vga_sync_pipe.md
VGA_SYNC_PIPE -- requirements
Module: vga_sync_pipe

Interface
REQ-001 SHALL have parameter H_VISIBLE, default 640, visible pixels per line.
REQ-002 SHALL have parameter H_FRONT_PORCH, default 16, pixels from end of visible region to hsync start.
REQ-003 SHALL have parameter H_SYNC_PULSE, default 96, hsync width in pixels.
REQ-004 SHALL have parameter H_WHOLE_LINE, default 800, pixels per line.
REQ-005 SHALL have parameter V_VISIBLE, default 480, visible lines per frame.
REQ-006 SHALL have parameter V_FRONT_PORCH, default 10, lines from end of visible region to vsync start.
REQ-007 SHALL have parameter V_SYNC_PULSE, default 2, vsync width in lines.
REQ-008 SHALL have parameter V_WHOLE_FRAME, default 525, lines per frame.
REQ-009 SHALL have parameter PIPE_DELAY, default 2, legal range 1..8, output latency in inc-qualified cycles.
REQ-010 SHALL have port clk, input, 1, sole clock.
REQ-011 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-012 SHALL have port inc, input, 1, qualifies x/y as a new pixel; same signal driving the upstream pixel iterator.
REQ-013 SHALL have port x, input, 10, current column from the pixel iterator.
REQ-014 SHALL have port y, input, 10, current row from the pixel iterator.
REQ-015 SHALL have port hsync, output, 1, horizontal sync, active-low.
REQ-016 SHALL have port vsync, output, 1, vertical sync, active-low.
REQ-017 SHALL have port visible, output, 1, pixel lies in the visible region.
REQ-018 SHALL have port frame_start, output, 1, one-cycle pulse aligned with pixel (0,0).
REQ-019 SHALL have port locked, output, 1, FSM in RUN.
REQ-020 SHALL have port resync_err, output, 1, one-cycle pulse when a coordinate discontinuity is detected.

Function
REQ-021 SHALL decode the stage-0 signals hsync_raw, vsync_raw, visible_raw and origin from x/y: hsync_raw active for x in [H_VISIBLE+H_FRONT_PORCH, +H_SYNC_PULSE), i.e. 656..751 by default; vsync_raw active for y in 490..491; visible for x<640 and y<480; origin for x==0 and y==0.
REQ-022 SHALL carry the decoded bits through a PIPE_DELAY-deep register chain that advances only on cycles with inc=1; with inc=0 all stages and outputs hold.
REQ-023 SHALL use a two-state FSM: SYNC_WAIT (the reset state) and RUN.
REQ-024 SHALL, in SYNC_WAIT, force hsync=1, vsync=1, visible=0, frame_start=0 and locked=0 regardless of pipe contents.
REQ-025 SHALL transition SYNC_WAIT->RUN on a cycle with inc=1 and origin=1; the chain is filled from that pixel on, so the first frame_start appears PIPE_DELAY inc-cycles later.
REQ-026 SHALL, in RUN, track the expected next coordinate: x+1, wrapping H_WHOLE_LINE-1 to 0 with y+1; y wraps V_WHOLE_FRAME-1 to 0.
REQ-027 SHALL, in RUN, when an inc=1 cycle presents x/y differing from the expected value, pulse resync_err for one cycle, return to SYNC_WAIT and flush the chain to the inactive values; if that same pixel is the origin, re-lock immediately.
REQ-028 SHALL assert frame_start for exactly one clk cycle per frame, even when inc stays low after the pixel arrives at the output.
REQ-029 SHALL drive every output from a register; no combinational path from x/y/inc to any output.

Reset
REQ-030 SHALL, while reset=0, set FSM=SYNC_WAIT, all pipe stages inactive, hsync=1, vsync=1, visible=0, frame_start=0, locked=0, resync_err=0.
REQ-031 SHALL apply reset asynchronously; after release the block stays in SYNC_WAIT until the next origin pixel, including when reset asserts mid-frame.

Structure
REQ-032 SHALL take its mode timing defaults from the shared VGA mode package/defines so that they match the parameters used by the pixel iterator.
REQ-033 SHALL put the FSM state enum in the shared VGA package.
REQ-034 SHALL implement the delay chain as one sub-module, vga_delay_line, parameterised by width and depth, with an enable input.

Verification
REQ-035 SHALL cover reset then origin: release reset at x=5, y=0 with inc=1, step the iterator -> locked=0, hsync=vsync=1 until (0,0); locked=1 the cycle after (0,0); frame_start pulses 2 inc-cycles later.
REQ-036 SHALL cover hsync timing: in RUN, present x=656 at cycle t -> hsync=0 after edge t+2; hsync=1 again for x=752 at t+96+2.
REQ-037 SHALL cover vsync and visible: y=490..491 -> vsync=0 for 1600 pixels; x=639, y=479 -> visible=1; x=640 -> visible=0.
REQ-038 SHALL cover a stall: hold inc=0 for 10 cycles mid-line -> all outputs frozen and no resync_err; resume -> sequence continues.
REQ-039 SHALL cover a discontinuity: jump x from 100 to 300 -> resync_err pulses once, locked=0, outputs go inactive, and relock occurs at the next (0,0).
REQ-040 SHALL cover async reset mid-frame: assert reset between clk edges -> outputs go to reset values immediately without waiting for an edge.
